// File: rtl/rs232c_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// rs232c_rx_fifo_if
//   Core-facing bundle of the RS-232C receiver: head-of-FIFO data, empty
//   indication, pop strobe, sticky error flags and their clear, fill level.
//   Handshake: rx_waiting=0 means rx_received_data holds a valid byte; a
//   cycle with rx_fifo_pop=1 and rx_waiting=0 consumes that byte at the next
//   rising clock edge. rx_fifo_pop while rx_waiting=1 has no effect.
//   Modports:
//     master - core side   (drives rx_fifo_pop, error_clear)
//     slave  - receiver    (drives data, status and flags)
//   Parameter FIFO_DEPTH_LOG2 must match the receiver instance.
// ---------------------------------------------------------------------------
interface rs232c_rx_fifo_if #(
  parameter int FIFO_DEPTH_LOG2 = 4
);
  logic [7:0]               rx_received_data;
  logic                     rx_waiting;
  logic                     rx_fifo_pop;
  logic                     error_clear;
  logic                     overflow;
  logic                     frame_error;
  logic                     parity_error;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;

  modport master (
    output rx_fifo_pop, error_clear,
    input  rx_received_data, rx_waiting, overflow, frame_error,
           parity_error, fifo_count
  );

  modport slave (
    input  rx_fifo_pop, error_clear,
    output rx_received_data, rx_waiting, overflow, frame_error,
           parity_error, fifo_count
  );
endinterface

// File: rtl/rs232c_rx_fifo.sv
// ---------------------------------------------------------------------------
// rs232c_rx_fifo
//   UART receiver (8N1, or 8E1 with RX_PARITY_EN defined) feeding a
//   first-word-fall-through receive FIFO.
//   Optional feature macro: RX_PARITY_EN (adds even-parity bit and check).
//   Ports:
//     clk         in   system clock, rising edge
//     reset       in   asynchronous active-low reset
//     rs_rx       in   serial line, idle high, asynchronous to clk
//     bus         slave modport of rs232c_rx_fifo_if (data/status/flags)
//     o_dbg_state out  current receiver FSM state encoding
// ---------------------------------------------------------------------------
module rs232c_rx_fifo #(
  parameter int CLK_PER_BIT     = 573,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rs_rx,
  rs232c_rx_fifo_if.slave   bus,
  output logic [2:0]        o_dbg_state
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int TW    = $clog2(CLK_PER_BIT);
  // Timer counts down to zero, so reload values are one less than the period.
  localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLK_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'((CLK_PER_BIT >> 1) - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                   r_state, w_next_state;
  logic                     r_sync1, r_sync2, r_rx_prev;
  logic                     w_rx, w_expire;
  logic [TW-1:0]            r_timer;
  logic [2:0]               r_bit_idx;
  logic [7:0]               r_shift;
  logic                     r_push;
  logic                     w_fe_set, w_pe_set, w_ovf_set;
  logic [7:0]               r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0] r_count;
  logic                     w_empty, w_full, w_do_pop, w_do_push;
  logic                     r_ovf, r_fe;

  // Two-flop synchroniser; idle-high reset value avoids a false start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rs_rx;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rx = r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  assign w_expire = (r_timer == '0);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      // Only a high-to-low transition starts a frame, so a line stuck low
      // after a framing error cannot retrigger.
      S_IDLE:   if (r_rx_prev && !w_rx) w_next_state = S_START;
      S_START:  if (w_expire) w_next_state = w_rx ? S_IDLE : S_DATA;
      S_DATA:   if (w_expire && (r_bit_idx == 3'd7)) begin
`ifdef RX_PARITY_EN
                  w_next_state = S_PARITY;
`else
                  w_next_state = S_STOP;
`endif
                end
      S_PARITY: if (w_expire) w_next_state = S_STOP;
      S_STOP:   if (w_expire) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

`ifdef RX_PARITY_EN
  logic r_par_bad, r_pe;
  // Even parity: XOR over data and parity bit must be zero.
  assign w_pe_set = (r_state == S_PARITY) && w_expire && ((^r_shift) ^ w_rx);
`else
  assign w_pe_set = 1'b0;
`endif
  assign w_fe_set = (r_state == S_STOP) && w_expire && !w_rx;

  // Bit timer, shift register and push strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_prev <= 1'b1;
      r_timer   <= HALF_RELOAD;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_push    <= 1'b0;
`ifdef RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_rx_prev <= w_rx;
      r_push    <= 1'b0;
      if (r_state == S_IDLE) begin
        r_timer   <= HALF_RELOAD;
        r_bit_idx <= 3'd0;
`ifdef RX_PARITY_EN
        r_par_bad <= 1'b0;
`endif
      end else if (w_expire) begin
        r_timer <= BIT_RELOAD;
        if (r_state == S_DATA) begin
          r_shift   <= {w_rx, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
`ifdef RX_PARITY_EN
        if (w_pe_set) r_par_bad <= 1'b1;
        if (r_state == S_STOP) r_push <= w_rx && !r_par_bad;
`else
        if (r_state == S_STOP) r_push <= w_rx;
`endif
      end else begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

  // FIFO control: pop only when non-empty; push at full succeeds only when a
  // pop frees the slot in the same cycle.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (FIFO_DEPTH_LOG2+1)'(DEPTH));
  assign w_do_pop  = bus.rx_fifo_pop && !w_empty;
  assign w_do_push = r_push && (!w_full || w_do_pop);
  assign w_ovf_set = r_push && w_full && !w_do_pop;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle beats error_clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_fe  <= 1'b0;
    end else begin
      if (w_ovf_set)            r_ovf <= 1'b1;
      else if (bus.error_clear) r_ovf <= 1'b0;
      if (w_fe_set)             r_fe  <= 1'b1;
      else if (bus.error_clear) r_fe  <= 1'b0;
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               r_pe <= 1'b0;
    else if (w_pe_set)        r_pe <= 1'b1;
    else if (bus.error_clear) r_pe <= 1'b0;
  end
  assign bus.parity_error = r_pe;
`else
  assign bus.parity_error = 1'b0;
`endif

  assign bus.rx_received_data = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign bus.rx_waiting       = w_empty;
  assign bus.fifo_count       = r_count;
  assign bus.overflow         = r_ovf;
  assign bus.frame_error      = r_fe;
  assign o_dbg_state          = r_state;

endmodule
